// File: rtl/terminal_cliente_if.sv
// Bundle of user-panel, cashier-request and cashier-response signals for the client terminal.
// slave = terminal side, master = user panel plus cashier side.
interface terminal_cliente_if;
    logic        inicio;
    logic [15:0] pin_usuario;
    logic        tipo_usuario;
    logic [31:0] monto_usuario;
    logic        balance_actualizado;
    logic        entregar_dinero;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        fondos_insuficientes;
    logic        tarjeta_recibida;
    logic        tipo_trans;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [31:0] monto;
    logic        monto_stb;
    logic        ocupado;
    logic        hecho;
    logic [2:0]  resultado;
    logic        bloqueado;

    modport slave (
        input  inicio, pin_usuario, tipo_usuario, monto_usuario,
        input  balance_actualizado, entregar_dinero, pin_incorrecto,
        input  advertencia, bloqueo, fondos_insuficientes,
        output tarjeta_recibida, tipo_trans, digito_stb, digito, monto,
        output monto_stb, ocupado, hecho, resultado, bloqueado
    );

    modport master (
        output inicio, pin_usuario, tipo_usuario, monto_usuario,
        output balance_actualizado, entregar_dinero, pin_incorrecto,
        output advertencia, bloqueo, fondos_insuficientes,
        input  tarjeta_recibida, tipo_trans, digito_stb, digito, monto,
        input  monto_stb, ocupado, hecho, resultado, bloqueado
    );
endinterface

// File: rtl/terminal_cliente.sv
// Client terminal session sequencer: card pulse, four spaced PIN digits, amount, then response wait.
// All outputs registered; a bloqueo response locks the terminal until reset.
module terminal_cliente #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    terminal_cliente_if.slave   bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TARJETA   = 3'd1;
    localparam logic [2:0] DIGITO    = 3'd2;
    localparam logic [2:0] ESPACIO   = 3'd3;
    localparam logic [2:0] MONTO     = 3'd4;
    localparam logic [2:0] ESPERA    = 3'd5;
    localparam logic [2:0] FIN       = 3'd6;
    localparam logic [2:0] BLOQUEADO = 3'd7;

    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [15:0] pin_reg;
    logic [1:0]  digit_idx;
    logic [1:0]  next_idx;
    logic [3:0]  gap_cnt;
    logic [15:0] wait_cnt;
    logic [2:0]  resp_code;
    logic        abort;

    always_comb begin
        resp_code = 3'd0;
        if (bus.bloqueo)                   resp_code = 3'd6;
        else if (bus.fondos_insuficientes) resp_code = 3'd5;
        else if (bus.advertencia)          resp_code = 3'd4;
        else if (bus.pin_incorrecto)       resp_code = 3'd3;
        else if (bus.entregar_dinero)      resp_code = 3'd2;
        else if (bus.balance_actualizado)  resp_code = 3'd1;
    end

    // FIN and BLOQUEADO are excluded so a lock never produces a second hecho pulse.
    assign abort    = bus.bloqueo && (state inside {TARJETA, DIGITO, ESPACIO, MONTO, ESPERA});
    assign next_idx = digit_idx + 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            pin_reg              <= '0;
            digit_idx            <= '0;
            gap_cnt              <= '0;
            wait_cnt             <= '0;
            bus.tarjeta_recibida <= 1'b0;
            bus.tipo_trans       <= 1'b0;
            bus.digito_stb       <= 1'b0;
            bus.digito           <= '0;
            bus.monto            <= '0;
            bus.monto_stb        <= 1'b0;
            bus.ocupado          <= 1'b0;
            bus.hecho            <= 1'b0;
            bus.resultado        <= '0;
            bus.bloqueado        <= 1'b0;
        end else begin
            bus.tarjeta_recibida <= 1'b0;
            bus.digito_stb       <= 1'b0;
            bus.digito           <= '0;
            bus.monto_stb        <= 1'b0;
            bus.hecho            <= 1'b0;
            if (abort) begin
                state         <= FIN;
                bus.hecho     <= 1'b1;
                bus.resultado <= 3'd6;
            end else begin
                case (state)
                    IDLE: if (bus.inicio) begin
                        pin_reg              <= bus.pin_usuario;
                        bus.tipo_trans       <= bus.tipo_usuario;
                        bus.monto            <= bus.monto_usuario;
                        bus.tarjeta_recibida <= 1'b1;
                        bus.ocupado          <= 1'b1;
                        state                <= TARJETA;
                    end
                    TARJETA: begin
                        bus.digito_stb <= 1'b1;
                        bus.digito     <= pin_reg[3:0];
                        digit_idx      <= 2'd0;
                        state          <= DIGITO;
                    end
                    DIGITO: begin
                        gap_cnt <= '0;
                        state   <= ESPACIO;
                    end
                    // The gap after the last digit also precedes the amount strobe.
                    ESPACIO: if (gap_cnt == GAP_LAST) begin
                        if (digit_idx == 2'd3) begin
                            bus.monto_stb <= 1'b1;
                            state         <= MONTO;
                        end else begin
                            digit_idx      <= next_idx;
                            bus.digito_stb <= 1'b1;
                            bus.digito     <= pin_reg[{next_idx, 2'b00} +: 4];
                            state          <= DIGITO;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                    MONTO: begin
                        wait_cnt <= '0;
                        state    <= ESPERA;
                    end
                    ESPERA: if (resp_code != 3'd0) begin
                        bus.resultado <= resp_code;
                        bus.hecho     <= 1'b1;
                        state         <= FIN;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.resultado <= 3'd7;
                        bus.hecho     <= 1'b1;
                        state         <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                    FIN: if (bus.resultado == 3'd6) begin
                        bus.bloqueado <= 1'b1;
                        state         <= BLOQUEADO;
                    end else begin
                        bus.ocupado    <= 1'b0;
                        bus.monto      <= '0;
                        bus.tipo_trans <= 1'b0;
                        state          <= IDLE;
                    end
                    default: state <= BLOQUEADO;
                endcase
            end
        end
    end
endmodule
